// File: rtl/s2p_rx.sv
// s2p_rx: serial-to-parallel receiver, LSB-first words on a valid/ready port.
// Optional even-parity bit per word when S2P_RX_PARITY_EN is defined.
module s2p_rx #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sync,
    input  logic         sin_valid,
    input  logic         sin,
    output logic         sin_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         parity_err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        COLLECT,
        STALL
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W-1:0]   sr;
    logic [W-1:0]   sr_d;
    logic [W-1:0]   shifted;
    logic [W-1:0]   word;
    logic [W-1:0]   dout_d;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_d;
    logic           dv_d;
    logic           done;

`ifdef S2P_RX_PARITY_EN
    logic           perr_q;
    logic           perr_d;
    logic           hold_q;
    logic           hold_d;
    logic           wperr;

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign sin_ready = (state == COLLECT);
    assign shifted   = {sin, sr[W-1:1]};

    // State, shift register, counter and output buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            sr         <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
`ifdef S2P_RX_PARITY_EN
            perr_q     <= 1'b0;
            hold_q     <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            sr         <= sr_d;
            cnt        <= cnt_d;
            dout       <= dout_d;
            dout_valid <= dv_d;
`ifdef S2P_RX_PARITY_EN
            perr_q     <= perr_d;
            hold_q     <= hold_d;
`endif
        end
    end

    // Next-state: bit accept, word completion, stall and drain
    always_comb begin
        state_d = state;
        sr_d    = sr;
        cnt_d   = cnt;
        dout_d  = dout;
        dv_d    = dout_valid;
        done    = 1'b0;
        word    = shifted;
`ifdef S2P_RX_PARITY_EN
        perr_d  = perr_q;
        hold_d  = hold_q;
        wperr   = 1'b0;
`endif

        if (dout_valid && dout_ready) begin
            dv_d = 1'b0;
        end

        unique case (state)
            COLLECT: begin
                if (sync) begin
                    cnt_d = '0;
                    if (sin_valid) begin
                        sr_d  = shifted;
                        cnt_d = CW'(1);
                    end
                end else if (sin_valid) begin
`ifdef S2P_RX_PARITY_EN
                    // parity bit is checked, never shifted into the data
                    if (cnt == CW'(W)) begin
                        done  = 1'b1;
                        word  = sr;
                        wperr = (^sr) ^ sin;
                    end else begin
                        sr_d  = shifted;
                        cnt_d = cnt + CW'(1);
                    end
`else
                    if (cnt == CW'(W - 1)) begin
                        done = 1'b1;
                        word = shifted;
                    end else begin
                        sr_d  = shifted;
                        cnt_d = cnt + CW'(1);
                    end
`endif
                end

                if (done) begin
                    cnt_d = '0;
                    if (!dout_valid || dout_ready) begin
                        dout_d = word;
                        dv_d   = 1'b1;
`ifdef S2P_RX_PARITY_EN
                        perr_d = wperr;
`endif
                    end else begin
                        // buffer busy: park the word in sr until drained
                        sr_d    = word;
                        state_d = STALL;
`ifdef S2P_RX_PARITY_EN
                        hold_d  = wperr;
`endif
                    end
                end
            end

            STALL: begin
                if (dout_ready) begin
                    dout_d  = sr;
                    dv_d    = 1'b1;
                    state_d = COLLECT;
`ifdef S2P_RX_PARITY_EN
                    perr_d  = hold_q;
`endif
                end
            end
        endcase
    end

endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: directed stimulus with a queue scoreboard for s2p_rx.
// A negedge monitor pops and compares every word the DUT hands off.
module tb_s2p_rx;

    localparam int W = 4;
`ifdef S2P_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sync;
    logic         sin_valid;
    logic         sin;
    logic         sin_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         parity_err;

    typedef struct packed {
        logic [W-1:0] w;
        logic         p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    s2p_rx #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .sin_ready  (sin_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic pexp(input logic bad);
        return PAR & bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sync      = s;
        sin_valid = 1'b1;
        sin       = b;
        tick();
        sin_valid = 1'b0;
        sync      = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic bad,
                             input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            if (!PAR && rdy_last && i == W - 1) dout_ready = 1'b1;
            send_bit(w[i], 1'b0);
        end
        if (PAR) begin
            if (rdy_last) dout_ready = 1'b1;
            send_bit((^w) ^ bad, 1'b0);
        end
        if (rdy_last) dout_ready = 1'b0;
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    // Scoreboard monitor: compare each word as it is consumed
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_word", 32'(dout), 32'(e.w));
                chk("sb_parity", 32'(parity_err), 32'(e.p));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        sync       = 1'b0;
        sin_valid  = 1'b0;
        sin        = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset then idle
        repeat (5) begin
            @(negedge clk);
            chk("idle_dout", 32'(dout), 32'h0);
            chk("idle_valid", 32'(dout_valid), 32'h0);
            chk("idle_ready", 32'(sin_ready), 32'h1);
        end
        tick();

        // single word, consumer always ready
        dout_ready = 1'b1;
        sb.push_back('{w: 4'b1011, p: pexp(1'b0)});
        send_word(4'b1011, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_valid", 32'(dout_valid), 32'h1);
        chk("t1_dout", 32'(dout), 32'hB);
        tick();
        @(negedge clk);
        chk("t1_drained", 32'(dout_valid), 32'h0);
        tick();

        // backpressure into stall
        dout_ready = 1'b0;
        sb.push_back('{w: 4'hA, p: pexp(1'b0)});
        sb.push_back('{w: 4'h3, p: pexp(1'b0)});
        send_word(4'hA, 1'b0, 1'b0);
        send_word(4'h3, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_ready", 32'(sin_ready), 32'h0);
        chk("stall_dout", 32'(dout), 32'hA);
        chk("stall_valid", 32'(dout_valid), 32'h1);
        tick();
        sin_valid = 1'b1;
        sin       = 1'b1;
        tick();
        tick();
        sin_valid = 1'b0;
        sin       = 1'b0;
        @(negedge clk);
        chk("stall_ready2", 32'(sin_ready), 32'h0);
        chk("stall_dout2", 32'(dout), 32'hA);
        tick();
        drain();
        @(negedge clk);
        chk("unstall_dout", 32'(dout), 32'h3);
        chk("unstall_valid", 32'(dout_valid), 32'h1);
        chk("unstall_ready", 32'(sin_ready), 32'h1);
        tick();
        drain();

        // completion and drain on the same edge
        sb.push_back('{w: 4'h6, p: pexp(1'b0)});
        send_word(4'h6, 1'b0, 1'b0);
        sb.push_back('{w: 4'h5, p: pexp(1'b0)});
        send_word(4'h5, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_valid", 32'(dout_valid), 32'h1);
        chk("t3_dout", 32'(dout), 32'h5);
        chk("t3_ready", 32'(sin_ready), 32'h1);
        tick();
        drain();

        // sync mid-word restarts with the sync-cycle bit
        dout_ready = 1'b1;
        sb.push_back('{w: 4'b1110, p: pexp(1'b0)});
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        if (PAR) send_bit(1'b1, 1'b0);
        @(negedge clk);
        chk("t4_dout", 32'(dout), 32'hE);
        chk("t4_valid", 32'(dout_valid), 32'h1);
        tick();
        dout_ready = 1'b0;

        // sync during stall keeps the held word
        sb.push_back('{w: 4'h9, p: pexp(1'b0)});
        sb.push_back('{w: 4'hC, p: pexp(1'b1)});
        send_word(4'h9, 1'b0, 1'b0);
        send_word(4'hC, 1'b1, 1'b0);
        sync = 1'b1;
        tick();
        tick();
        sync = 1'b0;
        @(negedge clk);
        chk("t4b_ready", 32'(sin_ready), 32'h0);
        tick();
        drain();
        @(negedge clk);
        chk("t4b_dout", 32'(dout), 32'hC);
        chk("t4b_perr", 32'(parity_err), 32'(pexp(1'b1)));
        tick();
        drain();

        // parity good then bad
        dout_ready = 1'b1;
        sb.push_back('{w: 4'b1011, p: pexp(1'b0)});
        send_word(4'b1011, 1'b0, 1'b0);
        sb.push_back('{w: 4'b1011, p: pexp(1'b1)});
        send_word(4'b1011, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_perr", 32'(parity_err), 32'(pexp(1'b1)));
        tick();
        dout_ready = 1'b0;

        // reset while stalled drops everything
        send_word(4'h7, 1'b0, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_stall_ready", 32'(sin_ready), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(dout_valid), 32'h0);
        chk("t6_ready", 32'(sin_ready), 32'h1);
        chk("t6_dout", 32'(dout), 32'h0);
        tick();
        dout_ready = 1'b1;
        sb.push_back('{w: 4'hD, p: pexp(1'b0)});
        send_word(4'hD, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_after", 32'(dout), 32'hD);
        tick();
        dout_ready = 1'b0;

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2p_rx.md
Name: s2p_rx

Overview:
- Serial-to-parallel receiver; the receiving end of the 4-bit shift-register link.
- The transmitter shifts right, so q[0] leaves first and words arrive LSB first.
- s2p_rx reassembles those bits into W-bit words and presents them on a valid/ready parallel port.
- A one-word output buffer plus a stall state on the serial side give lossless backpressure.

Parameters:
- W, 4, word width in bits (≥2); also the number of serial data bits per word.

Ports:
- clk  input  1  clock; all activity on the rising edge.
- rst  input  1  synchronous reset, active-high.
- sync  input  1  discards the partially assembled word; realigns the word boundary.
- sin_valid  input  1  serial bit present this cycle.
- sin  input  1  serial data bit, LSB of the word first.
- sin_ready  output  1  receiver accepts a bit this cycle.
- dout  output  W  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream consumes dout this cycle.
- parity_err  output  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge) overrides all other inputs.
  - Shift register = 0, bit counter cnt = 0, state = COLLECT.
  - dout = 0, dout_valid = 0, parity_err = 0, sin_ready = 1 from the next cycle.
  - Reset mid-word or mid-stall drops all held data.
- Bit accept: occurs when sin_valid & sin_ready.
  - sr <= {sin, sr[W-1:1]}, i.e. the bit enters at the MSB and the register shifts right.
  - cnt increments. After W accepts, the first received bit sits at sr[0].
- States: COLLECT and STALL.
- sin_ready = (state == COLLECT). This is combinational from state only; there is no path from sin_valid.
- Word completion: an accept with cnt == W-1 forms word w = {sin, sr[W-1:1]}.
  - If dout_valid == 0, or dout_valid & dout_ready this cycle:
    - dout <= w, dout_valid <= 1, cnt <= 0, stay in COLLECT.
    - Back-to-back words are possible with zero gap bits.
  - Otherwise:
    - sr <= w, cnt <= 0, state <= STALL.
- STALL:
  - No bits are accepted.
  - When dout_ready (with dout_valid = 1): dout <= sr, dout_valid stays 1, state <= COLLECT.
  - sin_ready returns to 1 on the following cycle.
- Output drain: dout_valid & dout_ready with no new word completing clears dout_valid.
  - dout holds its last value when not valid.
- Latency: the final bit accepted at edge N gives dout_valid = 1 after edge N, provided the buffer is free.
- sync (COLLECT only):
  - cnt <= 0 and the partial word is discarded.
  - If sin_valid is high in the same cycle, that bit is accepted as bit 0 of the new word (cnt <= 1).
- sync in STALL: ignored. The completed word is kept, and no partial word exists in that state.
- Stability:
  - dout and dout_valid are registered.
  - Once dout_valid = 1, dout must not change until the cycle after dout_ready.
- Counter: width $clog2(W+1). It never exceeds W-1 (W with parity), and wraps to 0 only via completion or sync.

Optional Feature:
- Macro S2P_RX_PARITY_EN.
- Defined:
  - Each word is followed by one extra serial bit carrying even parity over the W data bits.
  - Completion occurs on the parity accept (cnt == W); the data shift register is not shifted by the parity bit.
  - parity_err is registered alongside dout: it loads (^data) ^ parity_bit whenever dout loads, including from STALL.
  - parity_err is valid only while dout_valid = 1. The word is delivered regardless of the parity result.
- Undefined:
  - Words are exactly W bits.
  - parity_err is constant 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then sin_valid=0 for 5 cycles -> dout=0, dout_valid=0, sin_ready=1 throughout.
- Single word, W=4: send 1,1,0,1 with dout_ready=1 -> dout=4'b1011, dout_valid high exactly 1 cycle after the 4th accept.
- Backpressure, dout_ready=0:
  - Send 4'hA (bits 0,1,0,1) then 4'h3 (bits 1,1,0,0) -> after the 8th bit, sin_ready=0 and dout=4'hA.
  - Raise dout_ready for 1 cycle -> dout=4'h3, sin_ready=1 the next cycle.
  - Extra sin_valid pulses during the stall are not accepted.
- Simultaneous completion and drain: dout_valid=1 with dout_ready=1 on the same edge as the 4th bit of 4'h5 -> dout=4'h5, dout_valid stays 1, no stall.
- sync mid-word:
  - Send 1,0, then sync with sin_valid=1 & sin=0, then 1,1,1 -> dout=4'b1110; the first two bits are discarded.
  - sync asserted during STALL -> held word delivered intact.
- Parity (S2P_RX_PARITY_EN defined): send 1,1,0,1 then parity 1 -> dout=4'b1011, parity_err=0; repeat with parity 0 -> parity_err=1.
- Reset mid-stall: rst=1 while in STALL -> dout_valid=0 and sin_ready=1 the cycle after rst drops.
